ccir656_frame_feeder: RTL and testbench
=======================================

Name: ccir656_frame_feeder

Overview:
- Upstream stage of the frame-to-macroblock manager. Parses an ITU-R BT.656 (CCIR656) 4:2:2 byte stream: decodes timing reference codes (TRC), crops active video to frame_width x frame_height, and reorders Cb Y Cr Y into the Y,Cb,Y,Cr byte order the manager consumes on din1.
- Produces the manager's dstrb/dclr strobes; only field 0 (F=0) is forwarded.

Parameters:
frame_width, 144, active pixels per line forwarded; multiple of 16
frame_height, 80, active lines per frame forwarded; multiple of 16

Ports:
clk  in  1  system clock (54 MHz)
rst  in  1  asynchronous reset, active low
ena  in  1  clock enable; low freezes all state
vin  in  8  BT.656 byte
vin_strb  in  1  vin valid this cycle (nominally every 2nd clk)
dout  out  8  reordered video byte to manager din1
dstrb  out  1  dout valid, one-cycle pulse
dclr  out  1  frame start, one-cycle pulse
trc_err  out  1  one-cycle pulse on TRC protection-bit failure
line_cnt  out  10  active line index within current frame

Behaviour:
- Reset (rst=0): dout=0, dstrb=0, dclr=0, trc_err=0, line_cnt=0, FSM=HUNT, armed=0, chroma holding register empty, pixel counter=0.
- All logic advances only on clk edges with ena=1 and vin_strb=1; with ena=0, dstrb/dclr/trc_err are driven 0 and state holds.
- TRC FSM: HUNT -(FF)-> T1 -(00)-> T2 -(00)-> T3 -(any)-> XY decode -> HUNT or ACTIVE. Any unexpected byte in T1/T2 returns to HUNT (FF in T1 stays T1).
- XY byte: F=bit6, V=bit5, H=bit4. Valid iff bit7=1, P3=V^H, P2=F^H, P1=F^V, P0=F^V^H. Invalid: trc_err pulse, code ignored, FSM=HUNT.
- V=1 code: sets vblank flag.
- Frame start: first valid SAV (H=0) with F=0, V=0 while vblank flag set. Clears vblank, line_cnt=0, armed=1, dclr pulses in the cycle after the XY byte.
- SAV with F=0, V=0, armed=1, line_cnt<frame_height: FSM=ACTIVE, pixel counter=0. Otherwise FSM=HUNT (line skipped).
- ACTIVE, byte counter k (0..2*frame_width-1): even k = chroma -> store in holding reg; odd k = luma -> emit luma; on the next even k (or the FF that starts EAV) emit held chroma. Sequence Cb0 Y0 Cr0 Y1 emits Y0 Cb0 Y1 Cr0.
- Bytes with k>=2*frame_width are discarded (no dstrb); the held chroma of the last pair is still emitted when EAV's FF arrives.
- Emission: dout and dstrb registered, dstrb high exactly one cycle, one clk after the triggering vin_strb edge. At most one dstrb per input byte.
- EAV (H=1): leaving ACTIVE increments line_cnt (saturates at frame_height); at line_cnt==frame_height armed=0 until next frame start.
- Short line (EAV before k reaches 2*frame_width): pending chroma flushed, line still counted; no padding.
- F=1 codes: ignored for data, never forwarded.
- Async reset mid-line: no further output until a new frame start.

Test Plan:
- Clean frame: 2 fields, 80 active lines of 288 bytes, Cb=0x10+n, Y=0x40+n -> one dclr, exactly 80*288=23040 dstrb, first four dout = 0x40,0x10,0x41,0x11 (Y0,Cb0,Y1,Cr0).
- Long line (1440 active bytes, frame_width=144) -> 288 dstrb per line, byte 288 onward dropped, last dout of line = Cr71.
- Corrupt XY (0x80 with F=0,V=0,H=0 replaced by 0x81) -> trc_err pulse, that line produces no dstrb, line_cnt unchanged.
- 100 active lines supplied -> dstrb stops after line 80, line_cnt holds 80 until next V=1 then frame start, then dclr and line_cnt=0.
- ena=0 for 10 cycles mid-line and vin_strb held -> no dstrb, output resumes in order with no lost or duplicated byte.
- rst asserted mid-line 5 -> outputs 0 immediately; no dstrb until next V=1 and field-0 SAV, then dclr.

Source files
------------

// File: rtl/ccir656_frame_feeder.sv
// BT.656 4:2:2 front end for the frame-to-macroblock manager: decodes timing
// reference codes, crops field-0 active video and reorders Cb Y Cr Y to Y Cb Y Cr.
module ccir656_frame_feeder #(
  parameter int frame_width  = 144,
  parameter int frame_height = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] vin,
  input  logic       vin_strb,
  output logic [7:0] dout,
  output logic       dstrb,
  output logic       dclr,
  output logic       trc_err,
  output logic [9:0] line_cnt
);

  localparam int            LINE_BYTES = 2 * frame_width;
  localparam int            KW         = $clog2(LINE_BYTES + 1);
  localparam logic [KW-1:0] K_LAST     = KW'(LINE_BYTES);
  localparam logic [9:0]    LINES      = 10'(frame_height);

  typedef enum logic [2:0] {HUNT, T1, T2, T3, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic          step_p0;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    chroma_q, chroma_d;
  logic          chroma_full_q, chroma_full_d;
  logic          vblank_q, vblank_d;
  logic          armed_q, armed_d;
  logic [9:0]    line_d;
  logic          vld_p0;
  logic [7:0]    byte_p0;
  logic          dclr_p0;
  logic          err_p0;
  logic          xy_f, xy_v, xy_h;
  logic          sav_f0;
  logic          line_go;

  // Protection bits of the XY word must match the Hamming-style parity of F/V/H.
  function automatic logic xy_valid(input logic [7:0] b);
    logic f, v, h;
    f = b[6];
    v = b[5];
    h = b[4];
    return b[7] && (b[3] == (v ^ h)) && (b[2] == (f ^ h)) &&
           (b[1] == (f ^ v)) && (b[0] == (f ^ v ^ h));
  endfunction

  assign step_p0 = ena & vin_strb;
  assign xy_f    = vin[6];
  assign xy_v    = vin[5];
  assign xy_h    = vin[4];
  assign sav_f0  = !xy_f && !xy_v && !xy_h;
  // A pending frame start resets line_cnt to 0, so that SAV always opens line 0.
  assign line_go = vblank_q || (armed_q && (line_cnt < LINES));

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    chroma_d      = chroma_q;
    chroma_full_d = chroma_full_q;
    vblank_d      = vblank_q;
    armed_d       = armed_q;
    line_d        = line_cnt;
    vld_p0        = 1'b0;
    byte_p0       = chroma_q;
    dclr_p0       = 1'b0;
    err_p0        = 1'b0;
    if (step_p0) begin
      unique case (state_q)
        HUNT: begin
          if (vin == 8'hFF) state_d = T1;
        end
        T1: begin
          if (vin == 8'h00)      state_d = T2;
          else if (vin != 8'hFF) state_d = HUNT;
        end
        T2: begin
          state_d = (vin == 8'h00) ? T3 : HUNT;
        end
        T3: begin
          state_d = HUNT;
          if (!xy_valid(vin)) begin
            err_p0 = 1'b1;
          end else begin
            if (xy_v) vblank_d = 1'b1;
            if (sav_f0) begin
              if (vblank_q) begin
                vblank_d = 1'b0;
                armed_d  = 1'b1;
                line_d   = '0;
                dclr_p0  = 1'b1;
              end
              if (line_go) begin
                state_d       = ACTIVE;
                k_d           = '0;
                chroma_full_d = 1'b0;
              end
            end
          end
        end
        ACTIVE: begin
          if (vin == 8'hFF) begin
            // EAV preamble: flush the last held chroma and close the line.
            state_d       = T1;
            vld_p0        = chroma_full_q;
            chroma_full_d = 1'b0;
            if (line_cnt < LINES) line_d = line_cnt + 10'd1;
            if (line_cnt + 10'd1 >= LINES) armed_d = 1'b0;
          end else if (k_q < K_LAST) begin
            k_d = k_q + KW'(1);
            if (k_q[0]) begin
              vld_p0  = 1'b1;
              byte_p0 = vin;
            end else begin
              vld_p0        = chroma_full_q;
              chroma_d      = vin;
              chroma_full_d = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HUNT;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    chroma_q <= chroma_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q           <= '0;
      chroma_full_q <= 1'b0;
      vblank_q      <= 1'b0;
      armed_q       <= 1'b0;
      line_cnt      <= '0;
      dout          <= '0;
      dstrb         <= 1'b0;
      dclr          <= 1'b0;
      trc_err       <= 1'b0;
    end else begin
      k_q           <= k_d;
      chroma_full_q <= chroma_full_d;
      vblank_q      <= vblank_d;
      armed_q       <= armed_d;
      line_cnt      <= line_d;
      // p0 -> p1: registered output stage
      dstrb         <= vld_p0;
      dclr          <= dclr_p0;
      trc_err       <= err_p0;
      if (vld_p0) dout <= byte_p0;
    end
  end

endmodule

// File: tb/tb_ccir656_frame_feeder.sv
// Bench for ccir656_frame_feeder: BT.656 line generator with a line-level
// reference model (pair swap, crop, frame/line bookkeeping).
module tb_ccir656_frame_feeder;

  localparam int W   = 144;
  localparam int H   = 80;
  localparam int BPL = 2 * W;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] vin;
  logic       vin_strb;
  logic [7:0] dout;
  logic       dstrb;
  logic       dclr;
  logic       trc_err;
  logic [9:0] line_cnt;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;
  int n_dstrb = 0;
  int n_dclr  = 0;
  int n_err   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  bit m_vblank = 1'b0;
  bit m_armed  = 1'b0;
  int m_lines  = 0;

  ccir656_frame_feeder #(.frame_width(W), .frame_height(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .vin      (vin),
    .vin_strb (vin_strb),
    .dout     (dout),
    .dstrb    (dstrb),
    .dclr     (dclr),
    .trc_err  (trc_err),
    .line_cnt (line_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dstrb === 1'b1) begin
      got_q.push_back(dout);
      n_dstrb++;
    end
    if (dclr === 1'b1) n_dclr++;
    if (trc_err === 1'b1) n_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] make_xy(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  task automatic send(input logic [7:0] b, input bit gap_ok);
    vin      = b;
    vin_strb = 1'b1;
    @(negedge clk);
    if (gap_ok && ($urandom_range(15) == 0)) begin
      vin_strb = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_trc(input bit f, input bit v, input bit h, input bit bad);
    send(8'hFF, 1'b1);
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    send(make_xy(f, v, h) ^ {7'b0, bad}, 1'b0);
  endtask

  task automatic chk_stream(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_bytes"}, bad, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  // Blanking or field-1 line: never forwarded.
  task automatic send_blank(input bit f, input bit v, input int n);
    int snap;
    snap = n_dstrb;
    send_trc(f, v, 1'b0, 1'b0);
    chk("blank_dclr", 32'(dclr), 32'd0);
    chk("blank_trc_err", 32'(trc_err), 32'd0);
    if (v) m_vblank = 1'b1;
    for (int i = 0; i < n; i++) send(8'($urandom_range(254, 1)), 1'b1);
    send_trc(f, v, 1'b1, 1'b0);
    repeat (4) send(8'h80, 1'b1);
    chk("blank_dstrb", n_dstrb - snap, 0);
    chk("blank_line_cnt", 32'(line_cnt), m_lines);
  endtask

  // Field-0 active line with n data bytes; optional corrupt SAV, ena pause, reset.
  task automatic send_line(input int n, input bit bad, input bit pattern,
                           input int ena_at, input int rst_at);
    logic [7:0] a[$];
    logic [7:0] b;
    bit         start;
    bit         fwd;
    int         m;
    int         snap;
    snap  = n_dstrb;
    start = !bad && m_vblank;
    send_trc(1'b0, 1'b0, 1'b0, bad);
    chk("sav_trc_err", 32'(trc_err), 32'(bad));
    chk("sav_dclr", 32'(dclr), 32'(start));
    if (start) begin
      m_vblank = 1'b0;
      m_armed  = 1'b1;
      m_lines  = 0;
      chk("start_line_cnt", 32'(line_cnt), 32'd0);
    end
    fwd = !bad && m_armed && (m_lines < H);
    for (int i = 0; i < n; i++) begin
      if (pattern) b = (i % 2 == 0) ? 8'(8'h10 + i / 2) : 8'(8'h40 + i / 2);
      else         b = 8'($urandom_range(254, 1));
      if (i == ena_at) begin
        ena      = 1'b0;
        vin      = 8'($urandom_range(254, 1));
        vin_strb = 1'b1;
        repeat (10) begin
          @(negedge clk);
          chk("ena_low_dstrb", 32'(dstrb), 32'd0);
        end
        ena = 1'b1;
      end
      if (i == rst_at) begin
        rst = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dstrb", 32'(dstrb), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        m_armed  = 1'b0;
        m_vblank = 1'b0;
        m_lines  = 0;
        fwd      = 1'b0;
        snap     = n_dstrb;
      end
      a.push_back(b);
      send(b, i != 1);
      if (i == 1 && fwd) begin
        chk("first_luma_dstrb", 32'(dstrb), 32'd1);
        chk("first_luma_dout", 32'(dout), 32'(a[1]));
      end
    end
    m = (n < BPL) ? n : BPL;
    send(8'hFF, 1'b0);
    if (fwd && m > 0) begin
      chk("eav_flush_dstrb", 32'(dstrb), 32'd1);
      chk("eav_flush_dout", 32'(dout), 32'(a[2 * ((m - 1) / 2)]));
    end
    send(8'h00, 1'b1);
    send(8'h00, 1'b1);
    send(make_xy(1'b0, 1'b0, 1'b1), 1'b1);
    repeat (4) send(8'h10, 1'b1);
    if (fwd) begin
      for (int j = 0; 2 * j < m; j++) begin
        if (2 * j + 1 < m) exp_q.push_back(a[2 * j + 1]);
        exp_q.push_back(a[2 * j]);
      end
      m_lines++;
    end
    chk("line_dstrb", n_dstrb - snap, fwd ? m : 0);
    chk("line_cnt", 32'(line_cnt), m_lines);
  endtask

  initial begin
    int s_dstrb;
    int s_dclr;
    int s_err;
    rst      = 1'b0;
    ena      = 1'b0;
    vin      = 8'h00;
    vin_strb = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_dstrb", 32'(dstrb), 32'd0);
    chk("reset_dclr", 32'(dclr), 32'd0);
    chk("reset_trc_err", 32'(trc_err), 32'd0);
    chk("reset_line_cnt", 32'(line_cnt), 32'd0);
    rst = 1'b1;
    ena = 1'b1;
    @(negedge clk);

    // Frame 1: clean field 0 with the ramp pattern, then a short field 1.
    s_dstrb = n_dstrb;
    s_dclr  = n_dclr;
    send_blank(1'b0, 1'b1, 16);
    send_blank(1'b0, 1'b1, 16);
    for (int l = 0; l < H; l++) send_line(BPL, 1'b0, 1'b1, -1, -1);
    send_blank(1'b1, 1'b1, 16);
    send_blank(1'b1, 1'b0, 32);
    send_blank(1'b1, 1'b0, 32);
    chk("f1_first0", 32'(got_q[0]), 32'h40);
    chk("f1_first1", 32'(got_q[1]), 32'h10);
    chk("f1_first2", 32'(got_q[2]), 32'h41);
    chk("f1_first3", 32'(got_q[3]), 32'h11);
    chk_stream("f1_stream");
    chk("f1_dstrb_total", n_dstrb - s_dstrb, H * BPL);
    chk("f1_dclr_count", n_dclr - s_dclr, 1);
    chk("f1_trc_err_count", n_err, 0);
    chk("f1_line_cnt", 32'(line_cnt), H);

    // Frame 2: long, corrupt, ena-paused and short lines, 100 valid lines in all.
    s_dclr = n_dclr;
    s_err  = n_err;
    send_blank(1'b0, 1'b1, 16);
    send_line(1440, 1'b0, 1'b0, -1, -1);
    send_line(BPL, 1'b1, 1'b0, -1, -1);
    send_line(BPL, 1'b0, 1'b0, 100, -1);
    send_line(101, 1'b0, 1'b0, -1, -1);
    for (int l = 0; l < 97; l++) send_line(BPL, 1'b0, 1'b0, -1, -1);
    chk_stream("f2_stream");
    chk("f2_trc_err_count", n_err - s_err, 1);
    chk("f2_dclr_count", n_dclr - s_dclr, 1);
    chk("f2_line_cnt_sat", 32'(line_cnt), H);
    send_blank(1'b0, 1'b1, 16);
    chk("f2_line_cnt_hold", 32'(line_cnt), H);

    // Frame 3: reset in the middle of line 5, then recovery on the next frame.
    s_dclr = n_dclr;
    for (int l = 0; l < 5; l++) send_line(BPL, 1'b0, 1'b0, -1, -1);
    chk_stream("f3_pre_rst_stream");
    send_line(BPL, 1'b0, 1'b0, -1, 60);
    send_line(BPL, 1'b0, 1'b0, -1, -1);
    send_line(BPL, 1'b0, 1'b0, -1, -1);
    send_blank(1'b0, 1'b1, 16);
    send_line(BPL, 1'b0, 1'b0, -1, -1);
    send_line(BPL, 1'b0, 1'b0, -1, -1);
    chk_stream("f3_post_rst_stream");
    chk("f3_dclr_count", n_dclr - s_dclr, 2);
    chk("f3_line_cnt", 32'(line_cnt), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
